// File: rtl/trdemu_nmi_ctl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trdemu_nmi_ctl_pkg                                            |
// | Purpose  : Shared constants for the VG93 emulation NMI sequencer.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package trdemu_nmi_ctl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GUARD = 2'd3;

    localparam logic [15:0] NMI_VEC      = 16'h0066;
    localparam logic [7:0]  CLR_NMI_PORT = 8'hBE;

    // Counter width able to hold the larger of two lengths minus one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trdemu_downcnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trdemu_downcnt                                                |
// | Purpose  : Loadable down-counter that stops at zero, with zero flag.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module trdemu_downcnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/trdemu_nmi_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trdemu_nmi_ctl                                                |
// | Purpose  : Traps VG93 port accesses for emulated drives, raises NMI and  |
// |            holds the trap record until the handler releases it.          |
// | Options  : TRDEMU_WDOG_EN - handler watchdog (WDOG_W bits) in WAIT.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module trdemu_nmi_ctl #(
    parameter int NMI_LEN   = 16,
    parameter int GUARD_LEN = 8,
    parameter int WDOG_W    = 20
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        vg_rdwr_fclk,
    input  logic        vg_wr,
    input  logic [1:0]  vg_a,
    input  logic [7:0]  vg_wrdata,
    input  logic [1:0]  drv_sel,
    input  logic [3:0]  fdd_mask,
    input  logic        m1_fetch,
    input  logic [15:0] cpu_addr,
    input  logic        clr_nmi,
    output logic        nmi_req,
    output logic        in_trdemu,
    output logic        trap_busy,
    output logic [1:0]  trap_a,
    output logic        trap_wr,
    output logic [7:0]  trap_data,
    output logic        trap_err
);

    import trdemu_nmi_ctl_pkg::*;

    localparam int                 c_CNT_W    = cnt_width(NMI_LEN, GUARD_LEN);
    localparam logic [c_CNT_W-1:0] c_NMI_LD   = c_CNT_W'(NMI_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LD = c_CNT_W'(GUARD_LEN - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_trap;
    logic               w_vec_fetch;
    logic               w_latch;
    logic               w_err_set;
    logic               w_err_clr;
    logic               w_wdog_expire;
    logic               w_cnt_load;
    logic [c_CNT_W-1:0] w_cnt_ld_val;
    logic               w_cnt_dec;
    logic [c_CNT_W-1:0] w_cnt;
    logic               w_cnt_zero;

    assign w_trap      = vg_rdwr_fclk && fdd_mask[drv_sel];
    assign w_vec_fetch = m1_fetch && (cpu_addr == NMI_VEC);

    trdemu_downcnt #(
        .WIDTH      (c_CNT_W)
    ) u_cnt (
        .clk        (fclk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_ld_val),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_ld_val = c_NMI_LD;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trap) begin
                    w_state_nxt = ST_REQ;
                    w_latch     = 1'b1;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_REQ: begin
                w_err_set = w_trap;
                if (clr_nmi) begin
                    w_state_nxt  = ST_GUARD;
                    w_cnt_load   = 1'b1;
                    w_cnt_ld_val = c_GUARD_LD;
                end else if (w_vec_fetch || w_cnt_zero) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                // A watchdog timeout releases exactly like clr_nmi but flags the error.
                w_err_set = w_trap || w_wdog_expire;
                if (clr_nmi || w_wdog_expire) begin
                    w_state_nxt  = ST_GUARD;
                    w_err_clr    = clr_nmi;
                    w_cnt_load   = 1'b1;
                    w_cnt_ld_val = c_GUARD_LD;
                end
            end
            ST_GUARD: begin
                w_err_set = w_trap;
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            trap_a    <= 2'b00;
            trap_wr   <= 1'b0;
            trap_data <= 8'h00;
        end else if (w_latch) begin
            trap_a    <= vg_a;
            trap_wr   <= vg_wr;
            trap_data <= vg_wr ? vg_wrdata : 8'h00;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            trap_err <= 1'b0;
        end else if (w_err_set) begin
            trap_err <= 1'b1;
        end else if (w_err_clr) begin
            trap_err <= 1'b0;
        end
    end

`ifdef TRDEMU_WDOG_EN
    logic [WDOG_W-1:0] r_wdog;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge fclk) begin
        if (rst || (r_state != ST_WAIT)) begin
            r_wdog <= '0;
        end else if (!w_wdog_expire) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    assign w_wdog_expire = (r_state == ST_WAIT) && (&r_wdog);
`else
    assign w_wdog_expire = 1'b0;

    // WDOG_W only sizes the optional watchdog; an invalid value elaborates nothing.
    if (WDOG_W < 1) begin : g_wdog_w_unused
    end
`endif

    assign nmi_req   = (r_state == ST_REQ);
    assign in_trdemu = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign trap_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trdemu_nmi_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_trdemu_nmi_ctl                                             |
// | Purpose  : Directed scoreboard bench for the VG93 emulation NMI sequencer.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_trdemu_nmi_ctl;

    logic        fclk = 1'b0;
    logic        rst;
    logic        vg_rdwr_fclk;
    logic        vg_wr;
    logic [1:0]  vg_a;
    logic [7:0]  vg_wrdata;
    logic [1:0]  drv_sel;
    logic [3:0]  fdd_mask;
    logic        m1_fetch;
    logic [15:0] cpu_addr;
    logic        clr_nmi;
    logic        nmi_req;
    logic        in_trdemu;
    logic        trap_busy;
    logic [1:0]  trap_a;
    logic        trap_wr;
    logic [7:0]  trap_data;
    logic        trap_err;

    trdemu_nmi_ctl dut (
        .fclk         (fclk),
        .rst          (rst),
        .vg_rdwr_fclk (vg_rdwr_fclk),
        .vg_wr        (vg_wr),
        .vg_a         (vg_a),
        .vg_wrdata    (vg_wrdata),
        .drv_sel      (drv_sel),
        .fdd_mask     (fdd_mask),
        .m1_fetch     (m1_fetch),
        .cpu_addr     (cpu_addr),
        .clr_nmi      (clr_nmi),
        .nmi_req      (nmi_req),
        .in_trdemu    (in_trdemu),
        .trap_busy    (trap_busy),
        .trap_a       (trap_a),
        .trap_wr      (trap_wr),
        .trap_data    (trap_data),
        .trap_err     (trap_err)
    );

    always #5 fclk = ~fclk;

    typedef struct packed {
        logic [1:0] a;
        logic       wr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every new NMI presents a trap record; compare it with the oldest expectation.
    logic nmi_q = 1'b0;
    always @(negedge fclk) begin
        exp_t e;
        if (nmi_req && !nmi_q) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_nmi: got trap_a=%0d trap_data=%0h want no trap", trap_a, trap_data);
            end else begin
                e = exp_q.pop_front();
                chk("mon_trap_a", 32'(trap_a), 32'(e.a));
                chk("mon_trap_wr", 32'(trap_wr), 32'(e.wr));
                chk("mon_trap_data", 32'(trap_data), 32'(e.data));
            end
        end
        nmi_q <= nmi_req;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic strobe(input logic wr, input logic [1:0] a, input logic [7:0] d, input bit expect_trap);
        vg_rdwr_fclk = 1'b1;
        vg_wr        = wr;
        vg_a         = a;
        vg_wrdata    = d;
        if (expect_trap) exp_q.push_back({a, wr, (wr ? d : 8'h00)});
        cyc();
        vg_rdwr_fclk = 1'b0;
        vg_wr        = 1'b0;
        vg_wrdata    = 8'h00;
    endtask

    task automatic clr();
        clr_nmi = 1'b1;
        cyc();
        clr_nmi = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] addr);
        m1_fetch = 1'b1;
        cpu_addr = addr;
        cyc();
        m1_fetch = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (trap_busy && n < 40) begin
            cyc();
            n++;
        end
        chk(name, 32'(trap_busy), 32'd0);
    endtask

    task automatic wait_nmi_low(input string name);
        int n = 0;
        while (nmi_req && n < 40) begin
            cyc();
            n++;
        end
        chk(name, 32'(nmi_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1; vg_rdwr_fclk = 1'b0; vg_wr = 1'b0; vg_a = 2'b00; vg_wrdata = 8'h00;
        drv_sel = 2'd0; fdd_mask = 4'b0000; m1_fetch = 1'b0; cpu_addr = 16'h0000; clr_nmi = 1'b0;
        cyc(3);
        chk("reset_outputs", {nmi_req, in_trdemu, trap_busy, trap_a, trap_wr, trap_data, trap_err}, 32'd0);
        rst = 1'b0;
        fdd_mask = 4'b0001;
        cyc();

        // Write trap on emulated drive 0
        strobe(1'b1, 2'd3, 8'h5A, 1'b1);
        chk("t1_nmi_req", 32'(nmi_req), 32'd1);
        chk("t1_in_trdemu", 32'(in_trdemu), 32'd1);
        chk("t1_busy", 32'(trap_busy), 32'd1);

        // Fetch at the wrong address keeps NMI; #0066 drops it
        fetch(16'h0067);
        chk("t2_wrong_vec_nmi", 32'(nmi_req), 32'd1);
        cyc();
        fetch(16'h0066);
        chk("t2_vec_nmi_low", 32'(nmi_req), 32'd0);
        chk("t2_wait_in_trdemu", 32'(in_trdemu), 32'd1);
        cyc(3);
        chk("t2_wait_holds", 32'(in_trdemu), 32'd1);
        clr();
        chk("t2_clr_in_trdemu", 32'(in_trdemu), 32'd0);
        chk("t2_guard_busy", 32'(trap_busy), 32'd1);
        cyc(7);
        chk("t2_guard_last", 32'(trap_busy), 32'd1);
        cyc();
        chk("t2_guard_done", 32'(trap_busy), 32'd0);
        chk("t2_err_clear", 32'(trap_err), 32'd0);

        // Read trap, no fetch: NMI is exactly NMI_LEN wide
        strobe(1'b0, 2'd1, 8'h77, 1'b1);
        w = 0;
        while (nmi_req && w < 40) begin
            w++;
            cyc();
        end
        chk("t3_nmi_width", 32'(w), 32'd16);
        chk("t3_wait_state", {30'd0, in_trdemu, trap_busy}, 32'd3);
        clr();
        strobe(1'b1, 2'd0, 8'hAA, 1'b0);
        chk("t3_guard_trap_err", 32'(trap_err), 32'd1);
        chk("t3_guard_trap_no_nmi", 32'(nmi_req), 32'd0);
        wait_idle("t3_wait_idle");
        clr();
        chk("t3_clr_idle_keeps_err", 32'(trap_err), 32'd1);

        // Non-emulated drive is ignored
        drv_sel = 2'd1;
        strobe(1'b1, 2'd2, 8'h99, 1'b0);
        chk("t4_no_trap", {29'd0, nmi_req, in_trdemu, trap_busy}, 32'd0);
        chk("t4_latch_kept", {trap_a, trap_wr, trap_data}, {21'd0, 2'd1, 1'b0, 8'h00});

        // Trap and clr_nmi together in IDLE: trap wins; clr ending WAIT clears err
        fdd_mask = 4'b0010;
        clr_nmi = 1'b1;
        strobe(1'b1, 2'd2, 8'hC3, 1'b1);
        clr_nmi = 1'b0;
        chk("t5_trap_wins", 32'(nmi_req), 32'd1);
        wait_nmi_low("t5a_nmi_timeout");
        clr();
        chk("t5_err_cleared", 32'(trap_err), 32'd0);
        wait_idle("t5a_wait_idle");

        // Second trap in WAIT: error, latches kept; clr+trap together: set wins
        strobe(1'b1, 2'd1, 8'h81, 1'b1);
        wait_nmi_low("t5b_nmi_timeout");
        strobe(1'b0, 2'd0, 8'h11, 1'b0);
        chk("t5_wait_trap_err", 32'(trap_err), 32'd1);
        chk("t5_wait_latch", {trap_a, trap_wr, trap_data}, {21'd0, 2'd1, 1'b1, 8'h81});
        chk("t5_wait_no_nmi", 32'(nmi_req), 32'd0);
        clr_nmi = 1'b1;
        strobe(1'b1, 2'd3, 8'h22, 1'b0);
        clr_nmi = 1'b0;
        chk("t5_set_wins", 32'(trap_err), 32'd1);
        chk("t5_released", 32'(in_trdemu), 32'd0);
        chk("t5_latch_after", 32'(trap_data), 32'h81);
        wait_idle("t5b_wait_idle");

        // Reset mid-WAIT
        strobe(1'b1, 2'd2, 8'h44, 1'b1);
        fetch(16'h0066);
        chk("t6_in_wait", {30'd0, nmi_req, in_trdemu}, 32'd1);
        rst = 1'b1;
        cyc();
        chk("t6_reset_outputs", {nmi_req, in_trdemu, trap_busy, trap_a, trap_wr, trap_data, trap_err}, 32'd0);
        rst = 1'b0;
        cyc();

        // clr_nmi during REQ goes straight to GUARD
        strobe(1'b1, 2'd1, 8'h3C, 1'b1);
        clr();
        chk("t7_req_clr", {nmi_req, in_trdemu, trap_busy, trap_err}, 32'd2);
        wait_idle("t7_wait_idle");

        cyc(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
